// File: rtl/uart_mmio_ctrl_if.sv
// CPU load/store bus into the UART MMIO controller.
//   master : CPU side   - drives cpu_req/cpu_we/cpu_addr/cpu_wdata, receives cpu_rdata/ack/err
//   slave  : controller - receives the request, returns cpu_rdata/cpu_ack/cpu_err
interface uart_mmio_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO controller: decodes a 16-byte register window (TXDATA, RXDATA, STATUS, CTRL),
// sequences TX pushes with a full-FIFO stall and timeout, pops RX bytes on RXDATA reads and
// raises a level interrupt from the CTRL enables.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   bus (slave)        - CPU request/ack bus
//   tx_push, tx_data   - push strobe and byte to the UART TX FIFO
//   tx_full, tx_idle   - TX FIFO status
//   rx_pop             - pop strobe to the UART RX FIFO
//   rx_data, rx_empty  - RX FIFO head and status
//   irq                - level interrupt
module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned TX_TIMEOUT = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_mmio_ctrl_if.slave       bus,
  output logic                  tx_push,
  output logic [7:0]            tx_data,
  input  logic                  tx_full,
  input  logic                  tx_idle,
  output logic                  rx_pop,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  output logic                  irq
);

  typedef enum logic [1:0] {StIdle, StTxWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [1:0]       ctrl_q, ctrl_d;

  logic       in_win;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign in_win      = (bus.cpu_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = bus.cpu_addr[3:2];
  assign unused_bits = ^{bus.cpu_addr[1:0], bus.cpu_wdata[31:8]};

  assign irq = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_byte_d     = tx_byte_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    ctrl_d        = ctrl_q;
    tx_push       = 1'b0;
    tx_data       = 8'h00;
    rx_pop        = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = 32'h0;
    bus.cpu_err   = 1'b0;

    // Strobes are combinational, so gate the whole FSM while reset is held to keep
    // an aborted access from pushing or acking.
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            tx_byte_d = bus.cpu_wdata[7:0];
            rdata_d   = 32'h0;
            err_d     = 1'b0;
            state_d   = StResp;
            if (!in_win) begin
              err_d = 1'b1;
            end else begin
              unique case (reg_sel)
                2'd0: begin
                  if (bus.cpu_we) begin
                    if (!tx_full) begin
                      tx_push = 1'b1;
                      tx_data = bus.cpu_wdata[7:0];
                    end else begin
                      cnt_d   = '0;
                      state_d = StTxWait;
                    end
                  end
                end
                2'd1: begin
                  if (!bus.cpu_we) begin
                    rdata_d = {23'b0, rx_empty, rx_empty ? 8'h00 : rx_data};
                    rx_pop  = ~rx_empty;
                  end
                end
                2'd2: begin
                  if (!bus.cpu_we) rdata_d = {29'b0, tx_idle, ~tx_full, ~rx_empty};
                end
                2'd3: begin
                  if (bus.cpu_we) ctrl_d  = bus.cpu_wdata[1:0];
                  else            rdata_d = {30'b0, ctrl_q};
                end
              endcase
            end
          end
        end
        StTxWait: begin
          cnt_d = cnt_q + CNT_W'(1);
          // Checking tx_full first lets a push win over a simultaneous timeout.
          if (!tx_full) begin
            tx_push = 1'b1;
            tx_data = tx_byte_q;
            state_d = StResp;
          end else if (cnt_q == CNT_W'(TX_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
        StResp: begin
          bus.cpu_ack   = 1'b1;
          bus.cpu_rdata = rdata_q;
          bus.cpu_err   = err_q;
          state_d       = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tx_byte_q <= 8'h00;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      ctrl_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      ctrl_q    <= ctrl_d;
    end
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped controller that sits between the CPU load/store stage and the UART core.
- Decodes a 16-byte register window.
- Sequences TX pushes, with back-pressure stall and timeout, and RX pops.
- Exposes status and control registers.
- Generates a level interrupt.
- Only block allowed to drive the UART FIFO push/pop strobes.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 16-byte register window (16-byte aligned)
TX_TIMEOUT, 1024, max cycles a TX write waits for FIFO space before erroring
CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TX_TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  access request; held high, with stable fields, until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address
cpu_wdata  in  32  store data; only [7:0] used for TXDATA
cpu_rdata  out  32  load data; valid only while cpu_ack is high
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_ack: decode error or TX timeout
tx_push  out  1  one-cycle push strobe to the UART TX FIFO
tx_data  out  8  byte to push; valid while tx_push is high
tx_full  in  1  TX FIFO full
tx_idle  in  1  TX FIFO empty and shifter idle
rx_pop  out  1  one-cycle pop strobe to the UART RX FIFO
rx_data  in  8  head of the RX FIFO; valid when rx_empty is low
rx_empty  in  1  RX FIFO empty
irq  out  1  level interrupt

Behaviour:
- Register map (offset from BASE_ADDR; addr[1:0] ignored):
  - 0x0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 0x4 RXDATA: read returns {23'b0, empty, byte}. Pops only if not empty; if empty returns 32'h100 and no pop. Write is ignored but acked.
  - 0x8 STATUS: read-only {29'b0, tx_idle, !tx_full, !rx_empty}. Writes are ignored but acked.
  - 0xC CTRL: rw. Bit0 = rx_irq_en, bit1 = txidle_irq_en, bits [31:2] read 0.
- Out-of-window address: ack with cpu_err = 1, rdata = 0, no side effects.
- irq = (rx_irq_en & !rx_empty) | (txidle_irq_en & tx_idle), combinational from registered CTRL.
- FSM states: IDLE, TX_WAIT, RESP.
  - IDLE, cpu_req high:
    - Latch we/addr/wdata.
    - TXDATA write with !tx_full: tx_push = 1 this cycle, go to RESP.
    - TXDATA write with tx_full: clear counter, go to TX_WAIT.
    - RXDATA read: capture rx_data and rx_empty into the rdata register. If !rx_empty, rx_pop = 1 this cycle. Go to RESP.
    - All other accesses: perform the read/write, go to RESP.
  - TX_WAIT:
    - Counter increments each cycle.
    - When tx_full falls: tx_push = 1 with the latched byte, go to RESP.
    - If the counter reaches TX_TIMEOUT while tx_full is still high: set err, no push, go to RESP.
    - If tx_full falls on the same cycle the counter hits TX_TIMEOUT, the push wins.
  - RESP: cpu_ack = 1 for one cycle with the registered rdata/err, then go to IDLE.
- Latency:
  - Non-stalled access: ack exactly 1 cycle after acceptance (accept in cycle N, ack in N+1).
  - Stalled TX: ack 1 cycle after the push or timeout.
- cpu_req is ignored outside IDLE.
- A new request may be accepted in the cycle after ack at the earliest, giving a back-to-back throughput of 1 access per 2 cycles.
- tx_push and rx_pop are never asserted in the same cycle. Each strobe fires exactly once per access.
- cpu_rdata is 0 whenever cpu_ack is low.
- Reset:
  - State = IDLE, CTRL = 0, counter = 0.
  - All outputs low; irq = 0.
  - Reset during TX_WAIT or RESP aborts the access: no ack and no push.
  - The CPU side is reset concurrently.

Test Plan:
1. After reset, read CTRL, then read STATUS with rx_empty=1, tx_full=0, tx_idle=1 -> CTRL returns 0; STATUS returns 32'h6; each ack 1 cycle after req; irq=0.
2. Write 32'hABCD_EF41 to 0x1000_0000 with tx_full=0 -> tx_push for exactly 1 cycle with tx_data=8'h41; ack the next cycle; err=0.
3. Hold tx_full=1 for 5 cycles after a TX write -> no push for 5 cycles; push on the first cycle tx_full=0; ack 1 cycle later. Separately, hold tx_full=1 for TX_TIMEOUT cycles -> ack with err=1 and no push.
4. Read RXDATA with rx_data=8'h5A, rx_empty=0 -> rx_pop for 1 cycle, rdata=32'h5A. Repeat with rx_empty=1 -> rdata=32'h100, rx_pop never asserted.
5. Write CTRL=32'h3 with rx_empty=0, tx_idle=0 -> irq=1. Drive rx_empty=1 -> irq=0. Drive tx_idle=1 -> irq=1. Read CTRL returns 32'h3.
6. Access 0x1000_0010 and 0x0000_0000 -> ack with err=1, rdata=0, no strobes. Assert reset mid TX_WAIT -> no ack, no push; FSM back in IDLE.
